// File: rtl/sha_acc_pkg.sv
// Shared definitions for the SHA256 accelerator feed master.
// Holds the accelerator's fixed word-address map, the start command word
// and the feed FSM state encoding.
package sha_acc_pkg;

    localparam logic [4:0]  ADDR_BLK0   = 5'd0;
    localparam logic [4:0]  ADDR_CTRL   = 5'd16;
    localparam logic [4:0]  ADDR_STATUS = 5'd17;
    localparam logic [4:0]  ADDR_HASH0  = 5'd0;
    localparam logic [31:0] START_MAGIC = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_BLK,
        WR_START,
        POLL_WAIT,
        POLL_RD,
        RD_HASH,
        DONE
    } feed_state_t;

endpackage

// File: rtl/sha_feed_master.sv
// sha_feed_master
// Avalon-MM master feeding one 512-bit message block at a time into the
// SHA256 accelerator slave: 16 block-word writes, a start write, status
// polling until done, then 8 hash-word reads. The digest is offered
// downstream on a valid/ready port.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   blk_valid/ready     upstream block handshake, blk_data = 16 x 32-bit words
//   hash_valid/ready    downstream digest handshake, hash_data = 8 x 32-bit words
//   err                 one-cycle pulse when polling gives up
//   avm_*               Avalon-MM master port towards the accelerator
//
// state     | meaning
// IDLE      | blk_ready high, waiting for a block
// WR_BLK    | writing block word cnt to address cnt
// WR_START  | writing the start word to the control register
// POLL_WAIT | idle gap between status reads
// POLL_RD   | reading the status register
// RD_HASH   | reading hash word cnt
// DONE      | digest presented, waiting for hash_ready
module sha_feed_master
    import sha_acc_pkg::*;
#(
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [255:0] hash_data,
    output logic         err,
    output logic [4:0]   avm_address,
    output logic         avm_chipselect,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_waitrequest
);

    localparam int GAP_W  = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TIMEOUT);

    feed_state_t         state;
    logic [511:0]        blk_q;
    logic [3:0]          cnt;
    logic [GAP_W-1:0]    gap;
    logic [POLL_W-1:0]   polls;

    logic [3:0]          cnt_nxt;
    logic [POLL_W-1:0]   polls_nxt;

    assign cnt_nxt   = cnt + 4'd1;
    assign polls_nxt = polls + 1'b1;

    // All bus outputs are registered: each state loads the strobes/address/data
    // for the transaction that follows, so the bus never sees a combinational
    // path from avm_waitrequest or avm_readdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            blk_q          <= '0;
            cnt            <= '0;
            gap            <= '0;
            polls          <= '0;
            blk_ready      <= 1'b0;
            hash_valid     <= 1'b0;
            hash_data      <= '0;
            err            <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_read       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (blk_valid && blk_ready) begin
                        // First word comes straight from the input so the
                        // write strobe appears one cycle after the handshake.
                        blk_q          <= blk_data;
                        cnt            <= '0;
                        state          <= WR_BLK;
                        blk_ready      <= 1'b0;
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_address    <= ADDR_BLK0;
                        avm_writedata  <= blk_data[31:0];
                    end else begin
                        blk_ready <= 1'b1;
                    end
                end

                WR_BLK: begin
                    if (!avm_waitrequest) begin
                        if (cnt == 4'd15) begin
                            state         <= WR_START;
                            avm_address   <= ADDR_CTRL;
                            avm_writedata <= START_MAGIC;
                        end else begin
                            cnt           <= cnt_nxt;
                            avm_address   <= ADDR_BLK0 + {1'b0, cnt_nxt};
                            avm_writedata <= blk_q[{cnt_nxt, 5'b0} +: 32];
                        end
                    end
                end

                WR_START: begin
                    if (!avm_waitrequest) begin
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        polls         <= '0;
                        gap           <= '0;
                        if (POLL_GAP == 0) begin
                            state          <= POLL_RD;
                            avm_read       <= 1'b1;
                            avm_address    <= ADDR_STATUS;
                        end else begin
                            state          <= POLL_WAIT;
                            avm_chipselect <= 1'b0;
                        end
                    end
                end

                POLL_WAIT: begin
                    if (gap == GAP_LAST) begin
                        state          <= POLL_RD;
                        avm_chipselect <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= ADDR_STATUS;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end

                POLL_RD: begin
                    if (!avm_waitrequest) begin
                        polls <= polls_nxt;
                        if (avm_readdata[0]) begin
                            state       <= RD_HASH;
                            cnt         <= '0;
                            avm_address <= ADDR_HASH0;
                        end else if (polls_nxt == POLL_LAST) begin
                            state          <= IDLE;
                            err            <= 1'b1;
                            blk_ready      <= 1'b1;
                            avm_read       <= 1'b0;
                            avm_chipselect <= 1'b0;
                        end else if (POLL_GAP != 0) begin
                            state          <= POLL_WAIT;
                            gap            <= '0;
                            avm_read       <= 1'b0;
                            avm_chipselect <= 1'b0;
                        end
                        // With no gap the read strobe simply stays up for the next poll.
                    end
                end

                RD_HASH: begin
                    if (!avm_waitrequest) begin
                        hash_data[{cnt[2:0], 5'b0} +: 32] <= avm_readdata;
                        if (cnt == 4'd7) begin
                            state          <= DONE;
                            hash_valid     <= 1'b1;
                            avm_read       <= 1'b0;
                            avm_chipselect <= 1'b0;
                        end else begin
                            cnt         <= cnt_nxt;
                            avm_address <= ADDR_HASH0 + {1'b0, cnt_nxt};
                        end
                    end
                end

                DONE: begin
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        state      <= IDLE;
                        blk_ready  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_feed_master.sv
module tb_sha_feed_master;

    localparam int GAP = 4;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         hash_valid;
    logic         hash_ready;
    logic [255:0] hash_data;
    logic         err;
    logic [4:0]   avm_address;
    logic         avm_chipselect;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_waitrequest;

    always #5 clk = ~clk;

    sha_feed_master #(.POLL_GAP(GAP), .POLL_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_data       (blk_data),
        .hash_valid     (hash_valid),
        .hash_ready     (hash_ready),
        .hash_data      (hash_data),
        .err            (err),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t         exp_q[$];
    logic [255:0] exp_hash_q[$];
    int           stat_cyc[$];

    int n_checks = 0;
    int n_pass   = 0;

    // slave model configuration
    logic [31:0] hw[8];
    int          stat_zeros = 0;
    bit          stat_stuck = 1'b0;
    int          stall_addr = -1;
    int          stall_left = 0;

    // monitor state
    int          cyc = 0;
    int          hs_cyc = 0;
    bit          pending_hs = 1'b0;
    int          last_rd_cyc = 0;
    int          hv_rises = 0;
    int          err_cnt = 0;
    int          addr5_cnt = 0;
    bit          prev_hv = 1'b0;
    bit          prev_stall = 1'b0;
    logic [38:0] prev_bus;

    task automatic check(input bit ok, input string name,
                         input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(posedge clk) cyc++;

    // Slave model + scoreboard monitor, one process so that waitrequest and
    // readdata are settled before the acceptance decision is taken.
    always @(negedge clk) begin
        logic [38:0] bus;
        txn_t e;
        bus = {avm_write, avm_read, avm_address, avm_writedata};
        if (prev_stall) check(bus == prev_bus, "hold_during_wait", bus, prev_bus);
        if (avm_write || avm_read)
            check(!(avm_write && avm_read), "rw_exclusive", {avm_write, avm_read}, 2'b00);
        if (pending_hs && (avm_write || avm_read)) begin
            check(cyc - hs_cyc == 1, "first_write_latency", cyc - hs_cyc, 1);
            pending_hs = 1'b0;
        end
        if (blk_valid && blk_ready) begin
            hs_cyc = cyc;
            pending_hs = 1'b1;
        end

        if (avm_write && int'(avm_address) == stall_addr && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (avm_read && avm_address == 5'd17)
            avm_readdata = {31'b0, (!stat_stuck && stat_zeros == 0)};
        else if (avm_read)
            avm_readdata = hw[avm_address[2:0]];
        else
            avm_readdata = '0;

        if (avm_write && avm_address == 5'd5) addr5_cnt++;

        if ((avm_write || avm_read) && !avm_waitrequest) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_txn", bus, 0);
            end else begin
                e = exp_q.pop_front();
                check(e.rd == avm_read && e.addr == avm_address && (e.rd || e.data == avm_writedata),
                      "bus_txn", bus, {!e.rd, e.rd, e.addr, e.data});
            end
            if (avm_read && avm_address == 5'd17) begin
                if (stat_zeros > 0) stat_zeros--;
                stat_cyc.push_back(cyc);
            end
            if (avm_read && avm_address == 5'd7) last_rd_cyc = cyc;
        end

        if (hash_valid && !prev_hv) begin
            hv_rises++;
            check(cyc - last_rd_cyc == 1, "hash_valid_latency", cyc - last_rd_cyc, 1);
        end
        if (hash_valid && hash_ready) begin
            if (exp_hash_q.size() == 0) check(1'b0, "unexpected_hash", hash_data, 0);
            else begin
                logic [255:0] h;
                h = exp_hash_q.pop_front();
                check(hash_data == h, "hash_data", hash_data, h);
            end
        end
        if (err) err_cnt++;

        prev_hv    = hash_valid;
        prev_stall = (avm_write || avm_read) && avm_waitrequest;
        prev_bus   = bus;
    end

    // Queue the bus traffic and digest one block should produce, and program
    // the slave's status behaviour and hash words for that block.
    task automatic push_run(input logic [511:0] blk, input int zeros, input bit stuck,
                            input logic [31:0] hbase);
        txn_t t;
        logic [255:0] h;
        int n;
        for (int i = 0; i < 16; i++) begin
            t.rd = 1'b0; t.addr = 5'(i); t.data = blk[32*i +: 32];
            exp_q.push_back(t);
        end
        t.rd = 1'b0; t.addr = 5'd16; t.data = 32'hFFFF_FFFF;
        exp_q.push_back(t);
        n = stuck ? TMO : zeros + 1;
        for (int i = 0; i < n; i++) begin
            t.rd = 1'b1; t.addr = 5'd17; t.data = '0;
            exp_q.push_back(t);
        end
        for (int j = 0; j < 8; j++) hw[j] = hbase + 32'(j) * 32'h0101_0101;
        if (!stuck) begin
            for (int j = 0; j < 8; j++) begin
                t.rd = 1'b1; t.addr = 5'(j); t.data = '0;
                exp_q.push_back(t);
                h[32*j +: 32] = hw[j];
            end
            exp_hash_q.push_back(h);
        end
        stat_zeros = zeros;
        stat_stuck = stuck;
    endtask

    task automatic raise_block(input logic [511:0] d);
        @(posedge clk); #1;
        blk_data  = d;
        blk_valid = 1'b1;
    endtask

    task automatic complete_block(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!blk_ready) check(1'b0, {name, "_handshake_timeout"}, 0, 1);
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_hash_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0 && exp_hash_q.size() == 0, {name, "_drained"},
              exp_q.size() + exp_hash_q.size(), 0);
    endtask

    function automatic logic [511:0] ramp(input logic [31:0] base);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = base + 32'(i);
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b1;
        logic [511:0] b2;
        logic [255:0] h;
        int err0, hv0, n;

        reset = 1'b1;
        blk_valid = 1'b0;
        blk_data = '0;
        hash_ready = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check(blk_ready == 0 && hash_valid == 0 && err == 0, "reset_handshake_outs",
              {blk_ready, hash_valid, err}, 0);
        check(hash_data == 0, "reset_hash_data", hash_data, 0);
        check({avm_write, avm_read, avm_chipselect, avm_address, avm_writedata} == 0,
              "reset_bus", {avm_write, avm_read, avm_chipselect, avm_address, avm_writedata}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // 1: constant block, done on first poll
        b1 = {16{32'h6162_6380}};
        push_run(b1, 0, 1'b0, 32'hA000_0000);
        raise_block(b1);
        complete_block("t1");
        wait_drain("t1");
        check(err_cnt == 0, "t1_no_err", err_cnt, 0);

        // 2: waitrequest stall on word 5
        addr5_cnt = 0;
        stall_addr = 5;
        stall_left = 3;
        b1 = ramp(32'h1000_0000);
        push_run(b1, 0, 1'b0, 32'hB000_0000);
        raise_block(b1);
        complete_block("t2");
        wait_drain("t2");
        check(addr5_cnt == 4, "t2_word5_cycles", addr5_cnt, 4);
        stall_addr = -1;

        // 3: three not-done status reads before done
        stat_cyc.delete();
        b1 = ramp(32'h2000_0000);
        push_run(b1, 3, 1'b0, 32'hC000_0000);
        raise_block(b1);
        complete_block("t3");
        wait_drain("t3");
        check(stat_cyc.size() == 4, "t3_status_reads", stat_cyc.size(), 4);
        for (int i = 1; i < stat_cyc.size(); i++)
            check(stat_cyc[i] - stat_cyc[i-1] == GAP + 1, "t3_poll_spacing",
                  stat_cyc[i] - stat_cyc[i-1], GAP + 1);

        // 4: status stuck at 0 -> timeout
        stat_cyc.delete();
        err0 = err_cnt;
        hv0 = hv_rises;
        b1 = ramp(32'h3000_0000);
        push_run(b1, 0, 1'b1, 32'hD000_0000);
        raise_block(b1);
        complete_block("t4");
        wait_drain("t4");
        repeat (4) @(negedge clk);
        check(stat_cyc.size() == TMO, "t4_status_reads", stat_cyc.size(), TMO);
        check(err_cnt - err0 == 1, "t4_err_pulse_cycles", err_cnt - err0, 1);
        check(hv_rises == hv0, "t4_no_hash_valid", hv_rises - hv0, 0);
        check(blk_ready == 1'b1, "t4_back_to_idle", blk_ready, 1);

        // 5: downstream back-pressure, next block held waiting
        hash_ready = 1'b0;
        b1 = ramp(32'h4000_0000);
        push_run(b1, 0, 1'b0, 32'hE000_0000);
        raise_block(b1);
        complete_block("t5a");
        n = 0;
        while (!hash_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(hash_valid == 1'b1, "t5_hash_valid_seen", hash_valid, 1);
        h = exp_hash_q[0];
        b2 = ramp(32'h5000_0000);
        push_run(b2, 0, 1'b0, 32'h9000_0000);
        raise_block(b2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(hash_valid && hash_data == h && !blk_ready, "t5_hold",
                  {hash_valid, blk_ready, hash_data}, {2'b10, h});
        end
        @(posedge clk); #1 hash_ready = 1'b1;
        complete_block("t5b");
        wait_drain("t5");

        // 6: reset in the middle of the block writes
        b1 = ramp(32'h6000_0000);
        push_run(b1, 0, 1'b0, 32'h8000_0000);
        raise_block(b1);
        complete_block("t6a");
        n = 0;
        while (!(avm_write && avm_address == 5'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(avm_write && avm_address == 5'd9, "t6_reached_word9", avm_address, 9);
        #1 reset = 1'b0;
        #1;
        check({avm_write, avm_read, avm_chipselect} == 3'b000, "t6_strobes_drop",
              {avm_write, avm_read, avm_chipselect}, 0);
        check(blk_ready == 0 && hash_valid == 0, "t6_handshake_outs",
              {blk_ready, hash_valid}, 0);
        exp_q.delete();
        exp_hash_q.delete();
        pending_hs = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        b1 = ramp(32'h7000_0000);
        push_run(b1, 1, 1'b0, 32'h7700_0000);
        raise_block(b1);
        complete_block("t6b");
        wait_drain("t6");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
